// File: rtl/sample_frame_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sample_frame_buffer_if                                         |
// | Brief   : Sample-in / index-out handshake bundle for the frame buffer.   |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface sample_frame_buffer_if #(
   parameter int BITS     = 16,
   parameter int SEL_BITS = 7,
   parameter int DEPTH    = 128
);
   logic                  in_valid;
   logic [BITS-1:0]       in_data;
   logic                  in_ready;
   logic [DEPTH*BITS-1:0] frame_data;
   logic [SEL_BITS-1:0]   sel_output;
   logic                  sel_valid;
   logic                  sel_ready;
   logic                  frame_done;

   // master: the sample source plus the mux-select consumer
   modport master (
      output in_valid,
      output in_data,
      output sel_ready,
      input  in_ready,
      input  frame_data,
      input  sel_output,
      input  sel_valid,
      input  frame_done
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  sel_ready,
      output in_ready,
      output frame_data,
      output sel_output,
      output sel_valid,
      output frame_done
   );
endinterface
`default_nettype wire

// File: rtl/sample_frame_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sample_frame_buffer                                            |
// | Brief   : Fills a DEPTH-entry sample frame, then drains read indices     |
// |           to the downstream sample-select mux. Optional build macro:     |
// |           REVERSE_READ_EN (drain DEPTH-1 down to 0).                     |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sample_frame_buffer #(
   parameter int BITS     = 16,
   parameter int SEL_BITS = 7,
   parameter int DEPTH    = 128
) (
   input logic                  clk,
   input logic                  rst_n,
   sample_frame_buffer_if.slave bus
);

   localparam logic [0:0] S_FILL  = 1'b0;
   localparam logic [0:0] S_DRAIN = 1'b1;

   localparam logic [SEL_BITS-1:0] c_last = SEL_BITS'(DEPTH - 1);
   localparam logic [SEL_BITS-1:0] c_zero = '0;

`ifdef REVERSE_READ_EN
   localparam logic [SEL_BITS-1:0] c_rd_start = c_last;
   localparam logic [SEL_BITS-1:0] c_rd_end   = c_zero;
`else
   localparam logic [SEL_BITS-1:0] c_rd_start = c_zero;
   localparam logic [SEL_BITS-1:0] c_rd_end   = c_last;
`endif

   logic [0:0]            r_state;
   logic [SEL_BITS-1:0]   r_wr_ptr;
   logic [SEL_BITS-1:0]   r_rd_ptr;
   logic                  r_in_ready;
   logic                  r_sel_valid;
   logic                  r_frame_done;
   logic [BITS-1:0]       r_entry [DEPTH];

   logic                  w_wr_fire;
   logic                  w_rd_fire;
   logic                  w_wr_last;
   logic                  w_rd_last;
   logic [SEL_BITS-1:0]   w_rd_next;
   logic [DEPTH*BITS-1:0] w_frame;

   // Both fire terms use only registered qualifiers, so no input reaches an output combinationally.
   assign w_wr_fire = bus.in_valid & r_in_ready;
   assign w_rd_fire = bus.sel_ready & r_sel_valid;
   assign w_wr_last = (r_wr_ptr == c_last);
   assign w_rd_last = (r_rd_ptr == c_rd_end);

`ifdef REVERSE_READ_EN
   assign w_rd_next = r_rd_ptr - 1'b1;
`else
   assign w_rd_next = r_rd_ptr + 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_FILL;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_in_ready   <= 1'b1;
         r_sel_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_FILL: begin
               if (w_wr_fire) begin
                  if (w_wr_last) begin
                     r_state     <= S_DRAIN;
                     r_wr_ptr    <= '0;
                     r_rd_ptr    <= c_rd_start;
                     r_in_ready  <= 1'b0;
                     r_sel_valid <= 1'b1;
                  end else begin
                     r_wr_ptr <= r_wr_ptr + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (w_rd_fire) begin
                  if (w_rd_last) begin
                     r_state      <= S_FILL;
                     r_wr_ptr     <= '0;
                     r_rd_ptr     <= '0;
                     r_in_ready   <= 1'b1;
                     r_sel_valid  <= 1'b0;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_rd_ptr <= w_rd_next;
                  end
               end
            end
            default: begin
               r_state     <= S_FILL;
               r_wr_ptr    <= '0;
               r_rd_ptr    <= '0;
               r_in_ready  <= 1'b1;
               r_sel_valid <= 1'b0;
            end
         endcase
      end
   end

   // Entries persist across frames; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_entry[k] <= '0;
         end
      end else if (w_wr_fire) begin
         r_entry[r_wr_ptr] <= bus.in_data;
      end
   end

   always_comb begin
      w_frame = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_frame[k*BITS +: BITS] = r_entry[k];
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.sel_valid  = r_sel_valid;
   assign bus.sel_output = r_rd_ptr;
   assign bus.frame_done = r_frame_done;
   assign bus.frame_data = w_frame;

endmodule
`default_nettype wire

// File: tb/tb_sample_frame_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sample_frame_buffer                                         |
// | Brief   : Self-checking bench: vector table, directed corner sequences   |
// |           and randomized traffic against a frame-level reference model.  |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sample_frame_buffer;

   localparam int BITS     = 16;
   localparam int SEL_BITS = 7;
   localparam int DEPTH    = 128;

   logic clk;
   logic rst_n;

   sample_frame_buffer_if #(.BITS(BITS), .SEL_BITS(SEL_BITS), .DEPTH(DEPTH)) bus_if ();

   sample_frame_buffer #(.BITS(BITS), .SEL_BITS(SEL_BITS), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: a frame is a list of samples plus a count of indices consumed.
   bit          m_fill;
   int          m_wr;
   int          m_hs;
   bit          m_done;
   logic [15:0] m_ent [DEPTH];
   int          ord   [DEPTH];

   function automatic void model_reset();
      m_fill = 1'b1;
      m_wr   = 0;
      m_hs   = 0;
      m_done = 1'b0;
      for (int k = 0; k < DEPTH; k++) m_ent[k] = 16'h0;
   endfunction

   function automatic void model_step(input bit iv, input logic [15:0] d, input bit sr);
      m_done = 1'b0;
      if (m_fill) begin
         if (iv) begin
            m_ent[m_wr] = d;
            m_wr++;
            if (m_wr == DEPTH) begin
               m_fill = 1'b0;
               m_wr   = 0;
               m_hs   = 0;
            end
         end
      end else if (sr) begin
         m_hs++;
         if (m_hs == DEPTH) begin
            m_fill = 1'b1;
            m_done = 1'b1;
         end
      end
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_outputs(input string nm);
      logic [DEPTH*BITS-1:0] ef;
      int bad;
      chk({nm, ".in_ready"},   32'(bus_if.in_ready),   32'(m_fill));
      chk({nm, ".sel_valid"},  32'(bus_if.sel_valid),  32'(!m_fill));
      chk({nm, ".sel_output"}, 32'(bus_if.sel_output), m_fill ? 32'd0 : 32'(ord[m_hs]));
      chk({nm, ".frame_done"}, 32'(bus_if.frame_done), 32'(m_done));
      for (int k = 0; k < DEPTH; k++) ef[k*BITS +: BITS] = m_ent[k];
      tests++;
      if (bus_if.frame_data !== ef) begin
         fails++;
         bad = 0;
         for (int k = DEPTH - 1; k >= 0; k--)
            if (bus_if.frame_data[k*BITS +: BITS] !== ef[k*BITS +: BITS]) bad = k;
         $display("FAIL %s.frame_data: entry %0d got %0h expected %0h", nm, bad,
                  bus_if.frame_data[bad*BITS +: BITS], ef[bad*BITS +: BITS]);
      end
   endtask

   task automatic cycle(input bit iv, input logic [15:0] d, input bit sr, input string nm);
      bus_if.in_valid  = iv;
      bus_if.in_data   = d;
      bus_if.sel_ready = sr;
      model_step(iv, d, sr);
      @(posedge clk);
      #1;
      check_outputs(nm);
   endtask

   // Asserts reset away from any clock edge and checks values before the next edge.
   task automatic async_reset(input string nm);
      bus_if.in_valid  = 1'b0;
      bus_if.sel_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs(nm);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit          iv;
      logic [15:0] data;
      bit          sr;
      int          idx;
      logic [15:0] val;
   } vec_t;

   initial begin
      vec_t vecs [6];
      int   n_done;
      int   n_hs;
      int   cyc;

`ifdef REVERSE_READ_EN
      for (int i = 0; i < DEPTH; i++) ord[i] = DEPTH - 1 - i;
`else
      for (int i = 0; i < DEPTH; i++) ord[i] = i;
`endif

      vecs[0] = '{1'b1, 16'hAAAA, 1'b1, 0, 16'hAAAA};
      vecs[1] = '{1'b0, 16'hBBBB, 1'b1, 1, 16'h0000};
      vecs[2] = '{1'b1, 16'hBBBB, 1'b0, 1, 16'hBBBB};
      vecs[3] = '{1'b1, 16'hCCCC, 1'b1, 2, 16'hCCCC};
      vecs[4] = '{1'b0, 16'h1234, 1'b0, 3, 16'h0000};
      vecs[5] = '{1'b1, 16'h1234, 1'b1, 3, 16'h1234};

      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = 16'h0;
      bus_if.sel_ready = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Vector table: gapped writes in FILL, sel_ready must be ignored.
      for (int i = 0; i < 6; i++) begin
         cycle(vecs[i].iv, vecs[i].data, vecs[i].sr, "vec");
         chk($sformatf("vec%0d.entry", i), 32'(bus_if.frame_data[vecs[i].idx*BITS +: BITS]),
             32'(vecs[i].val));
         chk($sformatf("vec%0d.in_ready", i), 32'(bus_if.in_ready), 32'd1);
         chk($sformatf("vec%0d.sel_valid", i), 32'(bus_if.sel_valid), 32'd0);
      end

      async_reset("reset_mid_fill");
      chk("reset_mid_fill.frame_zero", 32'(bus_if.frame_data != '0), 32'd0);

      // Continuous fill.
      for (int k = 0; k < DEPTH; k++) cycle(1'b1, 16'(16'h1000 + k), 1'b0, "fill");
      for (int k = 0; k < DEPTH; k++)
         chk($sformatf("fill.entry%0d", k), 32'(bus_if.frame_data[k*BITS +: BITS]), 32'(16'h1000 + k));
      chk("fill.in_ready_low", 32'(bus_if.in_ready), 32'd0);
      chk("fill.first_index", 32'(bus_if.sel_output), 32'(ord[0]));

      // Drain with a stall every third cycle while DEAD is offered on the input.
      n_done = 0;
      n_hs   = 0;
      cyc    = 0;
      while (!m_fill && cyc < 1000) begin
         if (bus_if.sel_valid && (cyc % 3 != 2)) n_hs++;
         cycle(1'b1, 16'hDEAD, (cyc % 3 != 2), "drain");
         if (bus_if.frame_done) n_done++;
         cyc++;
      end
      chk("drain.timeout", 32'(cyc < 1000), 32'd1);
      chk("drain.handshakes", 32'(n_hs), 32'(DEPTH));
      chk("drain.done_pulses", 32'(n_done), 32'd1);
      cycle(1'b0, 16'h0, 1'b1, "post_done");
      chk("post_done.low", 32'(bus_if.frame_done), 32'd0);

      // Next frame starts at entry 0 after backpressure.
      cycle(1'b1, 16'h5A5A, 1'b0, "next_first");
      chk("next_first.entry0", 32'(bus_if.frame_data[15:0]), 32'h5A5A);
      chk("next_first.entry1_kept", 32'(bus_if.frame_data[31:16]), 32'h1001);

      // Random fill, then random drain interrupted by reset at index 60.
      cyc = 0;
      while (m_fill && cyc < 2000) begin
         cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), "rfill");
         cyc++;
      end
      chk("rfill.timeout", 32'(cyc < 2000), 32'd1);
      cyc = 0;
      n_done = 0;
      while (!(bus_if.sel_valid && bus_if.sel_output == 7'd60) && cyc < 2000) begin
         cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), "rdrain");
         if (bus_if.frame_done) n_done++;
         cyc++;
      end
      chk("rdrain.reach60", 32'(cyc < 2000), 32'd1);
      async_reset("reset_mid_drain");
      chk("reset_mid_drain.no_done", 32'(n_done), 32'd0);

      // A fresh random frame fills and drains normally.
      cyc = 0;
      n_done = 0;
      while (m_fill && cyc < 2000) begin
         cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), "nfill");
         cyc++;
      end
      while (!m_fill && cyc < 4000) begin
         cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), "ndrain");
         if (bus_if.frame_done) n_done++;
         cyc++;
      end
      chk("nframe.timeout", 32'(cyc < 4000), 32'd1);
      chk("nframe.done_pulses", 32'(n_done), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sample_frame_buffer.md
# sample_frame_buffer

- Captures a stream of BITS-wide samples into a DEPTH-entry register frame.
- Once the frame is full, it sequences the read index 0..DEPTH-1 through a valid/ready handshake.
- Sits directly upstream of the 128:1 sample-select mux in the CWT preprocessing path:
  - `frame_data` slices drive the mux data inputs.
  - `sel_output` drives the mux select.
- Fill and drain alternate, so the frame is stable for the whole drain.

## Interface
- `BITS`, 16, sample width.
- `SEL_BITS`, 7, index width; DEPTH = 2**SEL_BITS.
- `DEPTH`, 128, frame entries; must equal 2**SEL_BITS.

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `in_data` is presented.
- `in_data`  in  BITS  input sample.
- `in_ready`  out  1  block accepts samples (FILL state).
- `frame_data`  out  DEPTH*BITS  flattened frame; entry k on `[k*BITS +: BITS]`.
- `sel_output`  out  SEL_BITS  read index to mux select.
- `sel_valid`  out  1  `sel_output` is a valid read index (DRAIN state).
- `sel_ready`  in  1  downstream consumed the current index.
- `frame_done`  out  1  one-cycle pulse, frame fully drained.

## Operation
States:
- FILL (reset state):
  - `in_ready` = 1, `sel_valid` = 0.
  - On `in_valid` & `in_ready`: `entry[wr_ptr]` <= `in_data`, `wr_ptr` <= `wr_ptr` + 1.
  - Accepting the sample at `wr_ptr` = DEPTH-1 moves the block to DRAIN.
- DRAIN:
  - `in_ready` = 0, `sel_valid` = 1, `sel_output` = `rd_ptr`.
  - On `sel_valid` & `sel_ready`, `rd_ptr` steps to the next index.
  - The handshake on the final index moves the block to FILL, clears `wr_ptr` to 0 and pulses `frame_done`.
- Entry writes occur only in FILL; `in_valid` in DRAIN is ignored (no write, no pointer change).
- Entries are not cleared between frames; each entry keeps its previous-frame value until overwritten.
- Pointers are SEL_BITS wide. End of frame is detected by compare against DEPTH-1, not by overflow; the wrap to 0 is explicit.
- `sel_ready` in FILL is ignored.
- Gaps are legal: `in_valid` or `sel_ready` low simply holds the pointers.

## Timing
- Reset values (`rst_n` low, asynchronous):
  - state = FILL, `in_ready` = 1.
  - all entries = 0, `frame_data` = 0.
  - `wr_ptr` = 0, `rd_ptr` = 0, `sel_output` = 0.
  - `sel_valid` = 0, `frame_done` = 0.
- Write latency: a sample accepted at edge N is visible on `frame_data` after edge N.
- FILL→DRAIN: `sel_valid` rises in the cycle after the last sample is accepted, with `sel_output` = first index.
- `in_ready` and `sel_valid` are state-decoded registered values; there is no combinational path from `in_valid` or `sel_ready` to any output.
- One index per cycle with `sel_ready` held high, so a full drain takes exactly DEPTH cycles.
- `frame_done` is high for exactly the one cycle after the final handshake, coincident with `in_ready` returning to 1. It is never asserted otherwise.
- Minimum frame period with continuous handshakes is 2*DEPTH cycles.
- Reset asserted mid-fill or mid-drain:
  - the partial frame is discarded and all state returns to reset values immediately;
  - no `frame_done` is produced.

## Configuration
- `REVERSE_READ_EN` defined:
  - DRAIN starts at `rd_ptr` = DEPTH-1 and decrements;
  - the final index is 0;
  - used for time-reversed wavelet convolution.
- `REVERSE_READ_EN` undefined: DRAIN starts at 0, increments, and the final index is DEPTH-1.
- Fill order, the handshake and `frame_done` are identical in both builds.

## Test plan
- Reset then check idle outputs:
  - assert `rst_n` = 0 mid-cycle;
  - all outputs take reset values without a clock edge;
  - after release, `in_ready` = 1 and `sel_valid` = 0.
- Continuous fill:
  - `in_valid` = 1 for 128 cycles with `in_data` = 16'h1000 + k;
  - entry k = 16'h1000 + k;
  - `in_ready` falls and `sel_valid` = 1, `sel_output` = 0 in the next cycle.
- Drain with stalls:
  - during DRAIN, `sel_ready` = 1 except low on every third cycle;
  - `sel_output` steps 0..127 holding during stalls;
  - `frame_done` pulses once after index 127;
  - total 128 handshakes.
- Backpressure:
  - `in_valid` pulsed throughout DRAIN with `in_data` = 16'hDEAD;
  - no entry changes and `wr_ptr` stays 0;
  - the next frame starts writing at entry 0.
- Reset mid-drain:
  - at `sel_output` = 60 pulse `rst_n` low;
  - state = FILL, entries = 0, no `frame_done`;
  - a new 128-sample frame fills and drains normally.
- `REVERSE_READ_EN` build, same fill as the continuous-fill test:
  - `sel_output` sequence is 127 down to 0;
  - `frame_done` follows index 0.
